image_frame_scheduler: RTL and testbench
========================================

Name: image_frame_scheduler

Overview:
Frame-level controller that sequences one image through the pixel processing datapath.
- On a start command it latches the operation configuration and resets the processor.
- It then streams IMG_WIDTH*IMG_HEIGHT pixels from a source frame RAM into the processor, and writes every processor output beat into a destination frame RAM.
- It signals completion once the processor pipeline has drained.
- It sits between the host/config register block and the processor plus its two frame memories.

Parameters:
IMG_WIDTH, 512, pixels per line
IMG_HEIGHT, 512, lines per frame
ADDR_W, 18, frame RAM address width; must satisfy 2^ADDR_W >= IMG_WIDTH*IMG_HEIGHT
DRAIN_CYCLES, 8, quiet cycles with no processor output before the frame is declared done

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begin a frame
abort  in  1  one-cycle pulse; terminate the current frame
pause  in  1  level; while high, no new source reads are issued
cfg_op  in  2  operation code: 00 invert, 01 threshold, 10 edge, 11 blur
cfg_thresh  in  8  threshold value
busy  out  1  high from an accepted start until return to IDLE
done  out  1  one-cycle pulse when a frame completes or is aborted
aborted  out  1  sticky; frame ended by abort, cleared by the next accepted start
overflow  out  1  sticky; processor produced more outputs than the frame size, cleared by the next accepted start
out_count  out  ADDR_W+1  number of outputs written in the current/last frame
src_rd_en  out  1  source RAM read strobe
src_rd_addr  out  ADDR_W  source RAM address
src_rd_data  in  8  source RAM data, valid 1 cycle after src_rd_en
proc_rst  out  1  active-high synchronous reset to the processor
proc_op  out  2  latched cfg_op
proc_thresh  out  8  latched cfg_thresh
proc_pixel  out  8  pixel to the processor; combinational from src_rd_data
proc_valid  out  1  data-valid to the processor; src_rd_en delayed 1 cycle
proc_out_pixel  in  8  processor output pixel
proc_out_valid  in  1  processor output valid
dst_wr_en  out  1  destination RAM write strobe
dst_wr_addr  out  ADDR_W  destination RAM address
dst_wr_data  out  8  destination RAM write data

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE.
  - All outputs 0: busy, done, aborted, overflow, out_count, src_rd_en, src_rd_addr, proc_valid, dst_wr_en, proc_op, proc_thresh.
  - proc_rst = 1 while rst_n is low, and in IDLE.
  - Reset mid-frame discards the frame and produces no done pulse.
- FSM states: IDLE -> FLUSH -> STREAM -> DRAIN -> DONE -> IDLE.
- IDLE: proc_rst=1.
  - start latches cfg_op/cfg_thresh into proc_op/proc_thresh, clears out_count/aborted/overflow, sets busy, and goes to FLUSH.
  - start while busy is ignored; config does not change.
- FLUSH: exactly 1 cycle with proc_rst=1; then -> STREAM with read address 0.
- STREAM: proc_rst=0.
  - Each cycle with pause=0: src_rd_en=1, src_rd_addr=rd_ptr, rd_ptr increments.
  - pause=1: src_rd_en=0 and rd_ptr holds.
  - After issuing address IMG_WIDTH*IMG_HEIGHT-1 -> DRAIN.
  - proc_valid is src_rd_en registered, so it is high in the cycle that src_rd_data is valid.
- Output capture, in STREAM and DRAIN:
  - dst_wr_en = proc_out_valid; dst_wr_addr = out_count[ADDR_W-1:0]; dst_wr_data = proc_out_pixel.
  - out_count increments on each write.
  - If out_count == IMG_WIDTH*IMG_HEIGHT when proc_out_valid arrives: suppress the write, hold out_count, set overflow.
- DRAIN: quiet counter loads DRAIN_CYCLES on entry and on every proc_out_valid, and decrements otherwise. At 0 -> DONE.
  - The final proc_valid beat (1 cycle after the last read) is still emitted in DRAIN.
- DONE: done=1 for one cycle, busy drops, -> IDLE.
- Abort in FLUSH/STREAM/DRAIN:
  - Next state DONE; src_rd_en=0 that cycle; the in-flight proc_valid beat is dropped; aborted=1.
  - abort in IDLE or DONE is ignored.
  - start+abort in the same IDLE cycle: start wins.
- Config inputs are sampled only at the accepted start; changes mid-frame have no effect.
- Latency: start at cycle 0 -> FLUSH at cycle 1 -> first src_rd_en at cycle 2 -> first proc_valid at cycle 3.

Decomposition:
- Shared package: operation codes (OP_INVERT/OP_THRESH/OP_EDGE/OP_BLUR), FSM state encoding, and a FRAME_PIXELS localparam expression.
- One natural sub-module: frame_addr_counter. It is a pausable, load/clear, terminal-count address counter, instantiated for both rd_ptr and out_count.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=3, op=00, processor model echoes input after 1 cycle: start -> src_rd_en high for 12 consecutive cycles with addresses 0..11; dst writes 0..11; done pulses once after the 8 quiet cycles; out_count=12.
- Same setup with pause high on cycles 4-6 of STREAM: exactly 3 stalled read cycles; address sequence unbroken; out_count=12.
- Processor model emits 14 outputs: 12 writes, then overflow=1; dst_wr_en stays low for the extra 2; done still pulses.
- abort at the 5th STREAM cycle: no further reads; aborted=1; done pulses the next cycle; a subsequent start clears aborted/out_count.
- cfg_op changed from 01 to 11 mid-frame, and start pulsed while busy: proc_op stays 01; no restart; exactly one done.
- rst_n asserted low mid-STREAM: all outputs 0 immediately (asynchronous); no done; after release, state is IDLE with proc_rst=1.

Source files
------------

// File: rtl/image_frame_scheduler_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// image_frame_scheduler_pkg: shared op codes, FSM states, frame-size helper
// Rev 1.0
// ----------------------------------------------------------------------------
package image_frame_scheduler_pkg;

    localparam logic [1:0] OP_INVERT = 2'b00;
    localparam logic [1:0] OP_THRESH = 2'b01;
    localparam logic [1:0] OP_EDGE   = 2'b10;
    localparam logic [1:0] OP_BLUR   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } sched_state_t;

    function automatic int frame_pixels(input int width, input int height);
        return width * height;
    endfunction

endpackage
`default_nettype wire

// File: rtl/image_frame_scheduler_frame_addr_counter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_addr_counter: pausable clearable address counter with terminal flag
// Rev 1.0
// ----------------------------------------------------------------------------
module frame_addr_counter #(
    parameter int W        = 18,
    parameter int TC_VALUE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;
    assign o_tc    = (r_count == W'(TC_VALUE));

endmodule
`default_nettype wire

// File: rtl/image_frame_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// image_frame_scheduler: streams one frame through the pixel processor
// Rev 1.0
// ----------------------------------------------------------------------------
module image_frame_scheduler
    import image_frame_scheduler_pkg::*;
#(
    parameter int IMG_WIDTH    = 512,
    parameter int IMG_HEIGHT   = 512,
    parameter int ADDR_W       = 18,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              pause,
    input  logic [1:0]        cfg_op,
    input  logic [7:0]        cfg_thresh,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              overflow,
    output logic [ADDR_W:0]   out_count,
    output logic              src_rd_en,
    output logic [ADDR_W-1:0] src_rd_addr,
    input  logic [7:0]        src_rd_data,
    output logic              proc_rst,
    output logic [1:0]        proc_op,
    output logic [7:0]        proc_thresh,
    output logic [7:0]        proc_pixel,
    output logic              proc_valid,
    input  logic [7:0]        proc_out_pixel,
    input  logic              proc_out_valid,
    output logic              dst_wr_en,
    output logic [ADDR_W-1:0] dst_wr_addr,
    output logic [7:0]        dst_wr_data
);

    localparam int FRAME_PIXELS = frame_pixels(IMG_WIDTH, IMG_HEIGHT);
    localparam int QW           = $clog2(DRAIN_CYCLES + 1) + 1;

    sched_state_t   r_state;
    logic           r_busy;
    logic           r_done;
    logic           r_aborted;
    logic           r_overflow;
    logic           r_proc_rst;
    logic           r_rd_en_q;
    logic [1:0]     r_op;
    logic [7:0]     r_thresh;
    logic [QW-1:0]  r_quiet;

    logic              w_active;
    logic              w_abort;
    logic              w_start;
    logic              w_capture;
    logic              w_rd_en;
    logic              w_rd_last;
    logic              w_wr_en;
    logic              w_out_full;
    logic [ADDR_W-1:0] w_rd_ptr;
    logic [ADDR_W:0]   w_out_count;

    assign w_active  = (r_state == ST_FLUSH) || (r_state == ST_STREAM) || (r_state == ST_DRAIN);
    assign w_abort   = abort && w_active;
    assign w_start   = start && (r_state == ST_IDLE);
    assign w_capture = (r_state == ST_STREAM) || (r_state == ST_DRAIN);
    assign w_rd_en   = (r_state == ST_STREAM) && !pause && !abort;
    // A full frame already written means any further beat is surplus.
    assign w_wr_en   = w_capture && proc_out_valid && !w_out_full;

    frame_addr_counter #(
        .W        (ADDR_W),
        .TC_VALUE (FRAME_PIXELS - 1)
    ) u_rd_ptr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (r_state != ST_STREAM),
        .i_en    (w_rd_en),
        .o_count (w_rd_ptr),
        .o_tc    (w_rd_last)
    );

    frame_addr_counter #(
        .W        (ADDR_W + 1),
        .TC_VALUE (FRAME_PIXELS)
    ) u_out_count (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_start),
        .i_en    (w_wr_en),
        .o_count (w_out_count),
        .o_tc    (w_out_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            r_overflow <= 1'b0;
            r_proc_rst <= 1'b1;
            r_rd_en_q  <= 1'b0;
            r_op       <= OP_INVERT;
            r_thresh   <= 8'd0;
            r_quiet    <= '0;
        end else begin
            r_done    <= 1'b0;
            r_rd_en_q <= w_rd_en;
            if (w_capture && proc_out_valid && w_out_full) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_FLUSH;
                        r_busy     <= 1'b1;
                        r_op       <= cfg_op;
                        r_thresh   <= cfg_thresh;
                        r_aborted  <= 1'b0;
                        r_overflow <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (abort) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else begin
                        r_state    <= ST_STREAM;
                        r_proc_rst <= 1'b0;
                    end
                end
                ST_STREAM: begin
                    if (abort) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else if (w_rd_en && w_rd_last) begin
                        r_state <= ST_DRAIN;
                        r_quiet <= QW'(DRAIN_CYCLES);
                    end
                end
                ST_DRAIN: begin
                    // Done once DRAIN_CYCLES consecutive cycles pass without output.
                    if (abort) begin
                        r_state   <= ST_DONE;
                        r_done    <= 1'b1;
                        r_aborted <= 1'b1;
                    end else if (proc_out_valid) begin
                        r_quiet <= QW'(DRAIN_CYCLES);
                    end else if (r_quiet <= QW'(1)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_quiet <= r_quiet - QW'(1);
                    end
                end
                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_proc_rst <= 1'b1;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                    r_proc_rst <= 1'b1;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign aborted     = r_aborted;
    assign overflow    = r_overflow;
    assign out_count   = w_out_count;
    assign src_rd_en   = w_rd_en;
    assign src_rd_addr = w_rd_ptr;
    assign proc_rst    = r_proc_rst;
    assign proc_op     = r_op;
    assign proc_thresh = r_thresh;
    assign proc_pixel  = src_rd_data;
    assign proc_valid  = r_rd_en_q && !w_abort;
    assign dst_wr_en   = w_wr_en;
    assign dst_wr_addr = w_out_count[ADDR_W-1:0];
    assign dst_wr_data = proc_out_pixel;

endmodule
`default_nettype wire

// File: tb/tb_image_frame_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_image_frame_scheduler: directed checks on a 4x3 frame
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_image_frame_scheduler;
    import image_frame_scheduler_pkg::*;

    localparam int IMG_WIDTH    = 4;
    localparam int IMG_HEIGHT   = 3;
    localparam int ADDR_W       = 4;
    localparam int DRAIN_CYCLES = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              pause = 1'b0;
    logic [1:0]        cfg_op = 2'b00;
    logic [7:0]        cfg_thresh = 8'h00;
    logic              busy, done, aborted, overflow;
    logic [ADDR_W:0]   out_count;
    logic              src_rd_en;
    logic [ADDR_W-1:0] src_rd_addr;
    logic [7:0]        src_rd_data;
    logic              proc_rst;
    logic [1:0]        proc_op;
    logic [7:0]        proc_thresh;
    logic [7:0]        proc_pixel;
    logic              proc_valid;
    logic [7:0]        proc_out_pixel;
    logic              proc_out_valid;
    logic              dst_wr_en;
    logic [ADDR_W-1:0] dst_wr_addr;
    logic [7:0]        dst_wr_data;

    image_frame_scheduler #(
        .IMG_WIDTH    (IMG_WIDTH),
        .IMG_HEIGHT   (IMG_HEIGHT),
        .ADDR_W       (ADDR_W),
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .pause          (pause),
        .cfg_op         (cfg_op),
        .cfg_thresh     (cfg_thresh),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .overflow       (overflow),
        .out_count      (out_count),
        .src_rd_en      (src_rd_en),
        .src_rd_addr    (src_rd_addr),
        .src_rd_data    (src_rd_data),
        .proc_rst       (proc_rst),
        .proc_op        (proc_op),
        .proc_thresh    (proc_thresh),
        .proc_pixel     (proc_pixel),
        .proc_valid     (proc_valid),
        .proc_out_pixel (proc_out_pixel),
        .proc_out_valid (proc_out_valid),
        .dst_wr_en      (dst_wr_en),
        .dst_wr_addr    (dst_wr_addr),
        .dst_wr_data    (dst_wr_data)
    );

    always #5 clk = ~clk;

    // Source RAM holds 0x30+addr; processor echoes its input one cycle later.
    logic [7:0] r_src_q = 8'h00;
    logic       r_echo_v = 1'b0;
    logic [7:0] r_echo_p = 8'h00;
    logic       inj = 1'b0;
    int         cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (src_rd_en) r_src_q <= 8'h30 + 8'(src_rd_addr);
        r_echo_v <= proc_valid;
        r_echo_p <= proc_pixel;
    end
    assign src_rd_data    = r_src_q;
    assign proc_out_valid = r_echo_v | inj;
    assign proc_out_pixel = inj ? 8'hEE : r_echo_p;

    int         t0 = 0;
    int         rd_q[$];
    int         rd_first, rd_last, pv_first, wr_first, wr_last, wr_cnt, done_cnt, done_k;
    logic [7:0] dst_mem [16];
    int         snap_aborted, snap_cnt, snap_op, snap_thresh;

    always @(negedge clk) begin
        if (src_rd_en) begin
            rd_q.push_back(int'(src_rd_addr));
            if (rd_first < 0) rd_first = cyc - t0;
            rd_last = cyc - t0;
        end
        if (proc_valid && pv_first < 0) pv_first = cyc - t0;
        if (dst_wr_en) begin
            dst_mem[dst_wr_addr] = dst_wr_data;
            wr_cnt++;
            if (wr_first < 0) wr_first = cyc - t0;
            wr_last = cyc - t0;
        end
        if (done) begin
            done_cnt++;
            done_k = cyc - t0;
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        rd_q.delete();
        rd_first = -1; rd_last = -1; pv_first = -1;
        wr_first = -1; wr_last = -1; wr_cnt = 0;
        done_cnt = 0; done_k = -1;
        for (int i = 0; i < 16; i++) dst_mem[i] = 8'h00;
    endtask

    // Runs 45 cycles; k is the cycle index relative to the start pulse.
    task automatic run_frame(input int p_lo, input int p_hi, input int ab_at,
                             input int inj_lo, input int inj_hi, input int st2_at,
                             input logic [1:0] op0, input logic [1:0] op1, input int op_sw);
        clear_logs();
        for (int k = 0; k < 45; k++) begin
            @(posedge clk);
            #2;
            if (k == 0) t0 = cyc;
            start      = (k == 0) || (k == st2_at);
            pause      = (k >= p_lo) && (k <= p_hi);
            abort      = (k == ab_at);
            inj        = (k >= inj_lo) && (k <= inj_hi);
            cfg_op     = (k >= op_sw) ? op1 : op0;
            cfg_thresh = (k >= op_sw) ? 8'hA5 : 8'h5A;
            if (k == 1) begin
                #1;
                snap_aborted = int'(aborted);
                snap_cnt     = int'(out_count);
            end
            if (k == 6) begin
                #1;
                snap_op     = int'(proc_op);
                snap_thresh = int'(proc_thresh);
            end
        end
        start = 1'b0; pause = 1'b0; abort = 1'b0; inj = 1'b0;
    endtask

    initial begin
        clear_logs();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy",     busy, 0);
        chk("rst_done",     done, 0);
        chk("rst_proc_rst", proc_rst, 1);
        chk("rst_out_cnt",  out_count, 0);
        chk("rst_rd_en",    src_rd_en, 0);

        // Plain frame
        run_frame(99, 0, -1, 99, 0, -1, OP_INVERT, OP_INVERT, 99);
        chk("t1_rd_count", rd_q.size(), 12);
        for (int i = 0; i < 12; i++) chk("t1_rd_addr", rd_q[i], i);
        chk("t1_rd_first", rd_first, 2);
        chk("t1_rd_last",  rd_last, 13);
        chk("t1_pv_first", pv_first, 3);
        chk("t1_wr_first", wr_first, 4);
        chk("t1_wr_cnt",   wr_cnt, 12);
        for (int i = 0; i < 12; i++) chk("t1_dst_data", dst_mem[i], 8'h30 + i);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_k",   done_k, 24);
        chk("t1_out_cnt",  out_count, 12);
        chk("t1_busy",     busy, 0);
        chk("t1_proc_rst", proc_rst, 1);
        chk("t1_overflow", overflow, 0);

        // Pause during STREAM cycles 4-6 (k=5..7)
        run_frame(5, 7, -1, 99, 0, -1, OP_INVERT, OP_INVERT, 99);
        chk("t2_rd_count", rd_q.size(), 12);
        for (int i = 0; i < 12; i++) chk("t2_rd_addr", rd_q[i], i);
        chk("t2_rd_last",  rd_last, 16);
        chk("t2_out_cnt",  out_count, 12);
        chk("t2_done_cnt", done_cnt, 1);

        // Two surplus processor outputs after the frame
        run_frame(99, 0, -1, 16, 17, -1, OP_INVERT, OP_INVERT, 99);
        chk("t3_wr_cnt",   wr_cnt, 12);
        chk("t3_overflow", overflow, 1);
        chk("t3_out_cnt",  out_count, 12);
        chk("t3_done_cnt", done_cnt, 1);
        chk("t3_done_k",   done_k, 26);

        // Abort on the 5th STREAM cycle
        run_frame(99, 0, 6, 99, 0, -1, OP_INVERT, OP_INVERT, 99);
        chk("t4_rd_count", rd_q.size(), 4);
        chk("t4_rd_last",  rd_last, 5);
        chk("t4_aborted",  aborted, 1);
        chk("t4_done_k",   done_k, 7);
        chk("t4_done_cnt", done_cnt, 1);
        chk("t4_out_cnt",  out_count, 3);
        chk("t4_wr_cnt",   wr_cnt, 3);

        // Config change and start while busy
        run_frame(99, 0, -1, 99, 0, 5, OP_THRESH, OP_BLUR, 4);
        chk("t5_clr_aborted", snap_aborted, 0);
        chk("t5_clr_cnt",     snap_cnt, 0);
        chk("t5_op_mid",      snap_op, 1);
        chk("t5_thr_mid",     snap_thresh, 8'h5A);
        chk("t5_op_end",      proc_op, 1);
        chk("t5_rd_count",    rd_q.size(), 12);
        chk("t5_done_cnt",    done_cnt, 1);
        chk("t5_done_k",      done_k, 24);

        // Reset mid-STREAM
        clear_logs();
        @(posedge clk); #2; t0 = cyc; start = 1'b1; cfg_op = OP_EDGE;
        @(posedge clk); #2; start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy",     busy, 0);
        chk("t6_rd_en",    src_rd_en, 0);
        chk("t6_rd_addr",  src_rd_addr, 0);
        chk("t6_out_cnt",  out_count, 0);
        chk("t6_proc_op",  proc_op, 0);
        chk("t6_proc_rst", proc_rst, 1);
        chk("t6_pvalid",   proc_valid, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t6_done_cnt",  done_cnt, 0);
        chk("t6_post_busy", busy, 0);
        chk("t6_post_prst", proc_rst, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
